// File: rtl/weight_stream_sequencer.sv
// Streams DEPTH weight words from a falling-edge BRAM to a MAC, optionally reloading them from a host.
// Host load path is compiled in only when WSEQ_HOST_LOAD_EN is defined.
module weight_stream_sequencer #(
    parameter int DEPTH = 30,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          LOAD_REQ,
    input  logic [DW-1:0] LD_DATA,
    input  logic          LD_VALID,
    output logic          LD_READY,
    output logic [DW-1:0] W_DATA,
    output logic          W_VALID,
    input  logic          W_READY,
    output logic [AW-1:0] W_IDX,
    output logic          W_LAST,
    output logic          BUSY,
    output logic          DONE,
    output logic [AW-1:0] BRAM_ADDR,
    output logic [DW-1:0] BRAM_DI,
    output logic          BRAM_EN,
    output logic          BRAM_WE,
    input  logic [DW-1:0] BRAM_DO
);

`ifdef WSEQ_HOST_LOAD_EN
    typedef enum logic [2:0] {IDLE, LOAD, PRIME, STREAM, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, PRIME, STREAM, FIN} state_t;
`endif

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state, state_nx;
    logic [AW-1:0] idx, idx_nx;
    logic [AW-1:0] addr_q, addr_nx;
    logic [DW-1:0] di_q, di_nx;
    logic          en_q, en_nx;
    logic          we_q, we_nx;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            idx    <= '0;
            addr_q <= '0;
            di_q   <= '0;
            en_q   <= 1'b0;
            we_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            addr_q <= addr_nx;
            di_q   <= di_nx;
            en_q   <= en_nx;
            we_q   <= we_nx;
        end
    end

    // idx is the load counter in LOAD and the presented word index in STREAM.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        addr_nx  = addr_q;
        di_nx    = di_q;
        en_nx    = 1'b0;
        we_nx    = 1'b0;
        case (state)
            IDLE: begin
`ifdef WSEQ_HOST_LOAD_EN
                if (LOAD_REQ) begin
                    state_nx = LOAD;
                    idx_nx   = '0;
                end else
`endif
                if (START) begin
                    state_nx = PRIME;
                    idx_nx   = '0;
                end
            end
`ifdef WSEQ_HOST_LOAD_EN
            LOAD: begin
                if (LD_VALID) begin
                    en_nx   = 1'b1;
                    we_nx   = 1'b1;
                    addr_nx = idx;
                    di_nx   = LD_DATA;
                    if (idx == LAST_IDX) state_nx = FIN;
                    else                 idx_nx   = idx + AW'(1);
                end
            end
`endif
            PRIME: begin
                en_nx    = 1'b1;
                addr_nx  = '0;
                state_nx = STREAM;
            end
            STREAM: begin
                // Fetch the next word on the same edge as the beat so the stream never bubbles.
                if (W_READY) begin
                    if (idx == LAST_IDX) begin
                        state_nx = FIN;
                    end else begin
                        idx_nx  = idx + AW'(1);
                        en_nx   = 1'b1;
                        addr_nx = idx + AW'(1);
                    end
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef WSEQ_HOST_LOAD_EN
    assign LD_READY = (state == LOAD);
`else
    logic unused_ok;
    assign unused_ok = ^{LOAD_REQ, LD_VALID, LD_DATA};
    assign LD_READY  = 1'b0;
`endif

    assign W_VALID   = (state == STREAM);
    assign W_DATA    = BRAM_DO;
    assign W_IDX     = W_VALID ? idx : '0;
    assign W_LAST    = W_VALID && (idx == LAST_IDX);
    assign BUSY      = (state != IDLE);
    assign DONE      = (state == FIN);
    assign BRAM_ADDR = addr_q;
    assign BRAM_DI   = di_q;
    assign BRAM_EN   = en_q;
    assign BRAM_WE   = we_q;

endmodule

// File: tb/tb_weight_stream_sequencer.sv
// Directed scoreboard bench for weight_stream_sequencer with a falling-edge BRAM model.
// Load scenarios run only when WSEQ_HOST_LOAD_EN is defined.
module tb_weight_stream_sequencer;
    localparam int DEPTH = 30;
    localparam int AW    = 5;
    localparam int DW    = 16;

    typedef struct packed {logic [AW-1:0] idx; logic [DW-1:0] data;} beat_t;
    typedef struct packed {logic [AW-1:0] a;   logic [DW-1:0] d;}    wr_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          LOAD_REQ = 1'b0;
    logic [DW-1:0] LD_DATA = '0;
    logic          LD_VALID = 1'b0;
    logic          LD_READY;
    logic [DW-1:0] W_DATA;
    logic          W_VALID;
    logic          W_READY = 1'b1;
    logic [AW-1:0] W_IDX;
    logic          W_LAST;
    logic          BUSY;
    logic          DONE;
    logic [AW-1:0] BRAM_ADDR;
    logic [DW-1:0] BRAM_DI;
    logic          BRAM_EN;
    logic          BRAM_WE;
    logic [DW-1:0] BRAM_DO;

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    beat_t sq[$];
    wr_t   wq[$];

    weight_stream_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .LOAD_REQ(LOAD_REQ),
        .LD_DATA(LD_DATA), .LD_VALID(LD_VALID), .LD_READY(LD_READY),
        .W_DATA(W_DATA), .W_VALID(W_VALID), .W_READY(W_READY), .W_IDX(W_IDX), .W_LAST(W_LAST),
        .BUSY(BUSY), .DONE(DONE),
        .BRAM_ADDR(BRAM_ADDR), .BRAM_DI(BRAM_DI), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE),
        .BRAM_DO(BRAM_DO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // BRAM model: acts on the falling edge, holds DO while EN is low.
    always @(negedge CLK) begin
        if (BRAM_EN === 1'b1) begin
            if (BRAM_WE === 1'b1) begin
                wr_t w;
                mem[BRAM_ADDR] <= BRAM_DI;
                wr_cnt++;
                if (wq.size() == 0) begin
                    chk("extra_write", 32'(BRAM_ADDR), 32'hFFFF_FFFF);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", 32'(BRAM_ADDR), 32'(w.a));
                    chk("wr_data", 32'(BRAM_DI), 32'(w.d));
                end
            end else begin
                BRAM_DO <= mem[BRAM_ADDR];
                rd_cnt++;
            end
        end
    end

    always @(posedge CLK) if (DONE === 1'b1) done_cnt++;

    // Sample point and input-drive point: 7 time units after the rising edge.
    task automatic next_cycle();
        @(posedge CLK);
        #7;
    endtask

    task automatic run_stream(input int base, input int stall_idx, input int stall_n, input bit poke);
        int    stall_left = stall_n;
        int    stalls = 0;
        int    vc = 0;
        int    cyc = 0;
        int    rd0 = rd_cnt;
        int    d0 = done_cnt;
        bit    prev_stall = 1'b0;
        bit    stall;
        beat_t e;
        for (int i = 0; i < DEPTH; i++) sq.push_back('{idx: AW'(i), data: DW'(base + i)});
        W_READY = 1'b1;
        START = 1'b1;
        next_cycle();
        START = 1'b0;
        chk("prime_valid", 32'(W_VALID), 32'd0);
        chk("prime_busy", 32'(BUSY), 32'd1);
        next_cycle();
        while (sq.size() > 0 && cyc < 200) begin
            e = sq[0];
            if (prev_stall) chk("stall_en", 32'(BRAM_EN), 32'd0);
            chk("valid", 32'(W_VALID), 32'd1);
            stall = (32'(e.idx) == 32'(stall_idx)) && (stall_left > 0);
            W_READY = !stall;
            START = poke && (e.idx == AW'(10));
            if (stall) begin
                stall_left--;
                stalls++;
                chk("hold_idx", 32'(W_IDX), 32'(e.idx));
                chk("hold_data", 32'(W_DATA), 32'(e.data));
            end else begin
                void'(sq.pop_front());
                chk("beat_idx", 32'(W_IDX), 32'(e.idx));
                chk("beat_data", 32'(W_DATA), 32'(e.data));
                chk("beat_last", 32'(W_LAST), 32'(e.idx == AW'(DEPTH - 1)));
            end
            prev_stall = stall;
            vc++;
            cyc++;
            next_cycle();
        end
        START = 1'b0;
        W_READY = 1'b1;
        chk("stream_left", 32'(sq.size()), 32'd0);
        sq.delete();
        chk("fin_valid", 32'(W_VALID), 32'd0);
        chk("fin_done", 32'(DONE), 32'd1);
        chk("stream_cycles", 32'(vc), 32'(DEPTH + stalls));
        chk("stream_reads", 32'(rd_cnt - rd0), 32'(DEPTH));
        next_cycle();
        chk("idle_done", 32'(DONE), 32'd0);
        chk("idle_busy", 32'(BUSY), 32'd0);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int rd0;
        int d0;
        int wr0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(100 + i);

        // Reset state
        next_cycle();
        next_cycle();
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_valid", 32'(W_VALID), 32'd0);
        chk("rst_last", 32'(W_LAST), 32'd0);
        chk("rst_idx", 32'(W_IDX), 32'd0);
        chk("rst_ldready", 32'(LD_READY), 32'd0);
        chk("rst_en", 32'(BRAM_EN), 32'd0);
        chk("rst_we", 32'(BRAM_WE), 32'd0);
        chk("rst_addr", 32'(BRAM_ADDR), 32'd0);
        chk("rst_di", 32'(BRAM_DI), 32'd0);
        RST = 1'b0;
        next_cycle();

        // Full-rate stream, then a stalled stream, then START poked mid-stream
        run_stream(100, -1, 0, 1'b0);
        run_stream(100, 5, 3, 1'b0);
        run_stream(100, -1, 0, 1'b1);

        // Reset while presenting idx 12
        START = 1'b1;
        next_cycle();
        START = 1'b0;
        next_cycle();
        for (int k = 0; k < 12; k++) next_cycle();
        chk("pre_rst_idx", 32'(W_IDX), 32'd12);
        chk("pre_rst_data", 32'(W_DATA), 32'd112);
        rd0 = rd_cnt;
        d0 = done_cnt;
        RST = 1'b1;
        next_cycle();
        chk("abort_valid", 32'(W_VALID), 32'd0);
        chk("abort_idx", 32'(W_IDX), 32'd0);
        chk("abort_last", 32'(W_LAST), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_en", 32'(BRAM_EN), 32'd0);
        chk("abort_addr", 32'(BRAM_ADDR), 32'd0);
        RST = 1'b0;
        next_cycle();
        next_cycle();
        chk("abort_reads", 32'(rd_cnt - rd0), 32'd0);
        chk("abort_dones", 32'(done_cnt - d0), 32'd0);
        run_stream(100, -1, 0, 1'b0);

`ifdef WSEQ_HOST_LOAD_EN
        begin
            int i = 0;
            int cyc = 0;
            wr0 = wr_cnt;
            LOAD_REQ = 1'b1;
            START = 1'b1;
            next_cycle();
            LOAD_REQ = 1'b0;
            START = 1'b0;
            chk("load_ready", 32'(LD_READY), 32'd1);
            chk("load_busy", 32'(BUSY), 32'd1);
            chk("load_not_stream", 32'(W_VALID), 32'd0);
            while (i < DEPTH && cyc < 400) begin
                LD_VALID = ($urandom_range(0, 2) != 0);
                LD_DATA = DW'(32'hA000 + i);
                if (LD_VALID && LD_READY) begin
                    wq.push_back('{a: AW'(i), d: DW'(32'hA000 + i)});
                    i++;
                end
                cyc++;
                next_cycle();
            end
            chk("load_beats", 32'(i), 32'(DEPTH));
            LD_VALID = 1'b1;
            LD_DATA = 16'hBEEF;
            chk("load_fin_ready", 32'(LD_READY), 32'd0);
            chk("load_fin_done", 32'(DONE), 32'd1);
            next_cycle();
            chk("load_idle_ready", 32'(LD_READY), 32'd0);
            next_cycle();
            LD_VALID = 1'b0;
            chk("load_writes", 32'(wr_cnt - wr0), 32'(DEPTH));
            chk("load_pending", 32'(wq.size()), 32'd0);
            run_stream(32'hA000, -1, 0, 1'b0);
        end
`else
        wr0 = wr_cnt;
        LOAD_REQ = 1'b1;
        LD_VALID = 1'b1;
        LD_DATA = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            chk("noload_busy", 32'(BUSY), 32'd0);
            chk("noload_ready", 32'(LD_READY), 32'd0);
            chk("noload_we", 32'(BRAM_WE), 32'd0);
        end
        LOAD_REQ = 1'b0;
        LD_VALID = 1'b0;
        chk("noload_writes", 32'(wr_cnt - wr0), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/weight_stream_sequencer.md
WEIGHT_STREAM_SEQUENCER -- requirements
Module: weight_stream_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 30: number of weight words per neuron.
REQ-002 SHALL have parameter AW, default 5: BRAM address width, with DEPTH <= 2^AW.
REQ-003 SHALL have parameter DW, default 16: weight word width.
REQ-004 SHALL have port CLK, input, 1: the single clock; all logic updates on the rising edge.
REQ-005 SHALL have port RST, input, 1: synchronous active-high reset.
REQ-006 SHALL have port START, input, 1: request to stream all weights.
REQ-007 SHALL have port LOAD_REQ, input, 1: request to reload all weights from the host.
REQ-008 SHALL have ports LD_DATA (input, DW), LD_VALID (input, 1) and LD_READY (output, 1): host load handshake.
REQ-009 SHALL have ports W_DATA (output, DW), W_VALID (output, 1), W_READY (input, 1), W_IDX (output, AW) and W_LAST (output, 1): weight stream to the MAC.
REQ-010 SHALL have ports BUSY (output, 1) and DONE (output, 1): status.
REQ-011 SHALL have ports BRAM_ADDR (output, AW), BRAM_DI (output, DW), BRAM_EN (output, 1), BRAM_WE (output, 1) and BRAM_DO (input, DW): drive one weight BRAM; the BRAM reads/writes on falling CLK and holds DO while EN=0.

Function
REQ-012 SHALL implement states IDLE, LOAD, PRIME, STREAM and FIN.
REQ-013 IDLE: LOAD_REQ=1 -> LOAD; else START=1 -> PRIME; LOAD_REQ wins if both are asserted.
REQ-014 SHALL ignore START and LOAD_REQ outside IDLE.
REQ-015 BRAM_ADDR, BRAM_EN, BRAM_WE and BRAM_DI SHALL be registered; BRAM_EN and BRAM_WE SHALL be 1 for exactly one cycle per access and 0 otherwise.
REQ-016 PRIME: SHALL issue a read of addr 0 (BRAM_EN=1, BRAM_WE=0), then go to STREAM next cycle.
REQ-017 STREAM: W_VALID=1; W_DATA = BRAM_DO combinationally; W_IDX = index of the presented word; W_LAST = (W_IDX == DEPTH-1).
REQ-018 STREAM, beat (W_VALID & W_READY) with W_IDX < DEPTH-1: SHALL issue a read of W_IDX+1 in the same edge, giving the new word valid the next cycle (1 word/cycle sustained).
REQ-019 STREAM, W_READY=0: SHALL keep BRAM_EN=0 so that W_DATA, W_IDX and W_VALID hold stable.
REQ-020 STREAM, beat with W_LAST=1: SHALL go to FIN; W_VALID=0 next cycle.
REQ-021 FIN: DONE=1 for exactly one cycle, then IDLE.
REQ-022 LOAD: LD_READY=1; each beat (LD_VALID & LD_READY) SHALL write LD_DATA to address cnt (cnt = 0..DEPTH-1, ascending) the following cycle.
REQ-023 LOAD: after the beat with cnt = DEPTH-1, SHALL set LD_READY=0 and go to FIN; SHALL accept no extra beats.
REQ-024 LOAD: LD_VALID=0 cycles SHALL stall without a write or a cnt change.
REQ-025 BUSY SHALL be 1 in every state except IDLE.
REQ-026 Read latency from first START to the first W_VALID SHALL be 2 cycles.
REQ-027 Total STREAM cycles SHALL be DEPTH plus the number of stall cycles.

Reset
REQ-028 RST SHALL be sampled on the rising edge; while high, state = IDLE and all outputs = 0 (W_*, LD_READY, BUSY, DONE, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI); W_DATA follows BRAM_DO and is don't-care because W_VALID=0.
REQ-029 RST asserted mid-LOAD or mid-STREAM SHALL abort with no further BRAM access, no DONE pulse, and no change to BRAM contents beyond writes already issued.

Configuration
REQ-030 Macro WSEQ_HOST_LOAD_EN defined: LOAD state and load port SHALL function as specified.
REQ-031 Macro WSEQ_HOST_LOAD_EN undefined: LOAD_REQ and LD_* inputs SHALL be ignored, LD_READY=0, BRAM_WE=0 constantly, and the LOAD state SHALL be absent; ports SHALL remain present.

Verification
REQ-032 BRAM preloaded with w[i]=i+100, DEPTH=30, START pulse, W_READY=1: W_VALID 2 cycles later, 30 consecutive beats with data 100..129, W_LAST on idx 29, DONE 1 cycle after that.
REQ-033 Same setup, W_READY low for 3 cycles at idx 5: W_DATA=105 and W_IDX=5 held, BRAM_EN=0 throughout, stream resumes at 106.
REQ-034 LOAD_REQ and START in the same cycle, 30 LD beats of 0xA000+i with random LD_VALID gaps: 30 writes; a following START streams 0xA000..0xA01D.
REQ-035 RST at STREAM idx 12: next cycle all outputs 0, no DONE; a following START restarts from idx 0.
REQ-036 START pulsed during STREAM and 31st LD beat offered: both ignored; no 31st write; exactly one DONE.
REQ-037 Build without WSEQ_HOST_LOAD_EN, LOAD_REQ=1 with LD_VALID=1: BUSY stays 0, BRAM_WE never 1.
